// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between fetch and the MEM stage.
// Data has priority; a burst counter bounds how long fetch is held off.
module mem_arb #(
  parameter int XLEN        = 32,
  parameter int PC_SIZE     = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic               clk,
  input  logic               pc_rst_n,
  input  logic               if_req,
  input  logic [PC_SIZE-1:0] if_addr,
  input  logic               if_flush,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [XLEN-1:0]    if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [XLEN-1:0]    d_addr,
  input  logic [XLEN-1:0]    d_wdata,
  input  logic [2:0]         d_mode,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [XLEN-1:0]    d_rdata,
  output logic               bus_req,
  output logic               bus_we,
  output logic [XLEN-1:0]    bus_addr,
  output logic [XLEN-1:0]    bus_wdata,
  output logic [2:0]         bus_mode,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [XLEN-1:0]    bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  localparam logic [3:0] MAX_B = 4'(MAX_D_BURST);

  state_e            state_q, state_d;
  logic              own_d_q, own_d_d;
  logic [3:0]        streak_q, streak_d;
  logic              kill_q, kill_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [2:0]        bus_mode_q, bus_mode_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              pick_if, pick_d;

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    streak_d    = streak_q;
    kill_d      = kill_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_mode_d  = bus_mode_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    pick_if     = 1'b0;
    pick_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        // fetch overrides data only once the burst limit is hit
        if (d_req && !(if_req && streak_q == MAX_B)) begin
          pick_d = 1'b1;
        end else if (if_req) begin
          pick_if = 1'b1;
        end
        if (pick_d) begin
          state_d     = REQ;
          own_d_d     = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = d_we;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          bus_mode_d  = d_mode;
          if (!if_req) begin
            streak_d = 4'd0;
          end else if (streak_q != 4'hf) begin
            streak_d = 4'(streak_q + 4'd1);
          end
        end else if (pick_if) begin
          state_d     = REQ;
          own_d_d     = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = XLEN'(if_addr);
          bus_wdata_d = '0;
          bus_mode_d  = 3'b010;
          streak_d    = 4'd0;
        end
      end
      REQ: begin
        if (if_flush && !own_d_q) begin
          kill_d = 1'b1;
        end
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = bus_we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (own_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = bus_rdata;
          end else if (!kill_q && !if_flush) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus_rdata;
          end
        end else if (if_flush && !own_d_q) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      streak_q    <= 4'd0;
      kill_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_mode_q  <= 3'b000;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_mode_q  <= bus_mode_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = pick_if & pc_rst_n;
  assign d_gnt     = pick_d & pc_rst_n;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_mode  = bus_mode_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arb.md
# mem_arb

Memory-port arbiter for the 5-stage core. It shares a single unified memory port between the instruction-fetch stage (read-only) and the MEM stage (load/store). Data requests have priority, and a starvation guard bounds how long fetch can be held off. It sits between `ifecth`/`mem` and the memory bus, and allows one outstanding bus transaction at a time.

## Interface
- `XLEN`, 32, data width (`XLEN`)
- `PC_SIZE`, 32, fetch address width (`PC_SIZE`)
- `MAX_D_BURST`, 4, maximum consecutive data grants while fetch waits (1..15)

- `clk` in 1: the single clock; all state changes on its rising edge
- `pc_rst_n` in 1: reset, asynchronous, active-low
- `if_req` in 1: fetch request; held until `if_gnt`
- `if_addr` in PC_SIZE: fetch address
- `if_flush` in 1: fetch redirect (mispredict or jalr); kills the pending fetch response
- `if_gnt` out 1: fetch request accepted
- `if_rvalid` out 1: one-cycle fetch data valid
- `if_rdata` out XLEN: fetch data
- `d_req` in 1: data request; held until `d_gnt`
- `d_we` in 1: 1 = store, 0 = load
- `d_addr` in XLEN: data address
- `d_wdata` in XLEN: store data
- `d_mode` in 3: funct3 size/sign code, passed through unchanged
- `d_gnt` out 1: data request accepted
- `d_rvalid` out 1: one-cycle load data valid
- `d_rdata` out XLEN: load data
- `bus_req` out 1: bus request
- `bus_we` out 1: bus write enable
- `bus_addr` out XLEN: bus address
- `bus_wdata` out XLEN: bus write data
- `bus_mode` out 3: bus size code
- `bus_gnt` in 1: bus accepted the request
- `bus_rvalid` in 1: bus read data valid
- `bus_rdata` in XLEN: bus read data

## Operation
**State machine:** IDLE, REQ, WAIT.

**IDLE**
- If any request is present, pick a winner and assert its `x_gnt` combinationally for one cycle.
- At the edge, latch the winner's address, we, wdata and mode into the `bus_*` registers, record the owner, and go to REQ.
- Fetch is latched with `bus_we=0` and `bus_mode=3'b010`.

**REQ**
- `bus_req=1`, with all `bus_*` outputs stable until `bus_gnt`.
- On `bus_gnt`:
  - store: go to IDLE and drop `bus_req`; no rvalid is produced.
  - load or fetch: go to WAIT and drop `bus_req`.

**WAIT**
- On `bus_rvalid`, register `bus_rdata` into the owner's `x_rdata` and pulse the owner's `x_rvalid` on the next cycle; go to IDLE.
- `bus_rvalid` is ignored in IDLE and REQ.

**Arbitration**
- Data wins over fetch, except when `streak == MAX_D_BURST` and both request; fetch then wins.
- 4-bit `streak` register:
  - increments (saturating) when data is granted while `if_req=1`;
  - clears when fetch is granted;
  - clears when data is granted with `if_req=0`.

**Flush**
- `if_flush=1` while the owner is fetch in REQ or WAIT sets a `kill` flag.
- The bus transaction still completes, but `if_rvalid` is suppressed. `kill` clears on return to IDLE.
- `if_flush` together with `bus_rvalid` in the same cycle also suppresses `if_rvalid`.
- `if_flush` in IDLE has no effect; the fetch stage drops `if_req` itself.

**Reset**
- Async assertion forces IDLE, `streak=0`, `kill=0`, and all registered outputs to 0.
- `if_gnt`/`d_gnt` are forced to 0 while `pc_rst_n=0`.
- A bus response arriving after reset is ignored, since the block is in IDLE.

## Timing
- Reset values: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_mode`, `if_rvalid`, `d_rvalid`, `if_rdata`, `d_rdata`, `if_gnt`, `d_gnt` all 0.
- Grant is same-cycle as the request in IDLE. `bus_req` rises one cycle after the grant.
- Minimum read latency with zero-wait bus: request and grant at cycle 0; `bus_req`/`bus_gnt` at cycle 1; `bus_rvalid` at cycle 2; `x_rvalid` at cycle 3.
- Minimum store latency: grant at cycle 0; bus accept at cycle 1; next grant possible at cycle 2.
- The next grant may occur in the same cycle that `x_rvalid` is high (state IDLE).
- `x_rvalid` is exactly one cycle wide. `x_rdata` holds its value until the next response to that requester.
- `bus_gnt` and `bus_rvalid` may be delayed arbitrarily; `bus_*` outputs are held unchanged throughout.

## Test plan
- **Lone fetch:** `if_req`, `if_addr=0x100`; bus grants immediately; `bus_rdata=0x00500093` at cycle 2.
  - Required: `if_gnt` at cycle 0, `bus_req`/`bus_addr=0x100`/`bus_mode=010` at cycle 1, `if_rvalid` with `0x00500093` at cycle 3.
- **Simultaneous requests:** fetch and a load to `0x2000` arrive together.
  - Required: `d_gnt` first; fetch is granted in the IDLE cycle after `d_rvalid`'s transaction completes.
- **Starvation guard:** `MAX_D_BURST=4`; `d_req` held continuously with `if_req` high.
  - Required: data, data, data, data, fetch, then data again.
- **Store with 3-cycle `bus_gnt` delay:** `d_addr=0x40`, `d_wdata=0xDEADBEEF`, `d_mode=010`.
  - Required: `bus_*` stable for 3 cycles; no `d_rvalid`; back to IDLE one cycle after `bus_gnt`.
- **Flush:** pulse `if_flush` while a fetch is in WAIT, then repeat with the flush coincident with `bus_rvalid`.
  - Required: no `if_rvalid` in either case; the next request is granted normally.
- **Reset mid-WAIT:** drop `pc_rst_n` during WAIT; after release, drive `bus_rvalid=1`.
  - Required: all outputs 0 during reset; the stray `bus_rvalid` is ignored; no `x_rvalid`.
